fetch_seq: RTL

Next-PC sequencer for the instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter and picks each cycle's next fetch address from reset, exception entry, ERET return, branch/jump redirect, stall hold and sequential increment. It drives the word address into the 4096-word instruction ROM and supplies PC and PC+8 (link value) to the IF/ID register. A redirect that arrives during a stall is buffered and applied once the stall releases, so the decode stage can issue it once and retire it.

---
 rtl/fetch_seq_pkg.sv | 20 ++
 rtl/fetch_seq_if.sv | 28 ++
 rtl/fetch_seq.sv | 56 +++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared constants and types for the fetch sequencer and its neighbours.
package fetch_seq_pkg;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam int          IM_AW      = 12;

  typedef logic [31:0] instr_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

  // ROM word index for a PC: (pc - RESET_PC) >> 2, truncated so high PCs alias.
  function automatic logic [IM_AW-1:0] imem_index(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - RESET_PC;
    return off[IM_AW+1:2];
  endfunction
endpackage

// File: rtl/fetch_seq_if.sv
// Control inputs and fetch outputs between the pipeline and the PC sequencer.
interface fetch_seq_if;
  import fetch_seq_pkg::*;

  logic             stall_i;
  logic             redir_valid_i;
  logic [31:0]      redir_target_i;
  logic             exc_req_i;
  logic             eret_req_i;
  logic [31:0]      epc_i;
  logic [31:0]      pc_o;
  logic [31:0]      pc8_o;
  logic [IM_AW-1:0] imem_addr_o;
  logic             fetch_exc_o;
  logic             pend_o;

  // Pipeline side: drives control, consumes fetch address.
  modport master (
    output stall_i, redir_valid_i, redir_target_i, exc_req_i, eret_req_i, epc_i,
    input  pc_o, pc8_o, imem_addr_o, fetch_exc_o, pend_o
  );

  // Sequencer side.
  modport slave (
    input  stall_i, redir_valid_i, redir_target_i, exc_req_i, eret_req_i, epc_i,
    output pc_o, pc8_o, imem_addr_o, fetch_exc_o, pend_o
  );
endinterface

// File: rtl/fetch_seq.sv
// Next-PC sequencer for the IF stage. Owns the PC, buffers a redirect that
// arrives while stalled, and derives ROM index / link value from the PC.
module fetch_seq
  import fetch_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fetch_seq_if.slave  fs
);

  logic [31:0]  pc;
  logic         pend_valid;
  logic [31:0]  pend_target;
  fetch_state_e state;

  // Next-PC selection; exception/ERET override stall, a fresh redirect beats
  // a buffered one, and a redirect seen in a stall is replayed on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      state       <= ST_RUN;
    end else begin
      state <= fs.stall_i ? ST_HOLD : ST_RUN;
      if (fs.exc_req_i) begin
        pc         <= EXC_VECTOR;
        pend_valid <= 1'b0;
      end else if (fs.eret_req_i) begin
        pc         <= fs.epc_i;
        pend_valid <= 1'b0;
      end else if (fs.stall_i) begin
        if (fs.redir_valid_i) begin
          pend_target <= fs.redir_target_i;
          pend_valid  <= 1'b1;
        end
      end else if (fs.redir_valid_i) begin
        pc         <= fs.redir_target_i;
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        pc         <= pend_target;
        pend_valid <= 1'b0;
      end else begin
        pc <= pc + 32'd4;
      end
    end
  end

  // Outputs depend only on registered state; misaligned PCs are flagged, not fixed.
  assign fs.pc_o        = pc;
  assign fs.pc8_o       = pc + 32'd8;
  assign fs.imem_addr_o = imem_index(pc);
  assign fs.fetch_exc_o = |pc[1:0];
  assign fs.pend_o      = pend_valid;

endmodule
